// File: rtl/mem_port_arbiter_if.sv
// Single-port RAM command/response bus shared between the arbiter (master)
// and the RAM (slave).
interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_ready;
  logic [31:0]   ram_rdata;

  modport master (
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_ready, ram_rdata
  );

  modport slave (
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_ready, ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and MEM stages onto one single-port RAM, data first,
// freezing the pipeline until every pending request of the stall window is served.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [AW-1:0]        if_addr,
  input  logic                 flush,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic [AW-1:0]        mem_addr,
  input  logic [31:0]          mem_wdata,
  mem_port_arbiter_if.master   ram,
  output logic [31:0]          if_rdata,
  output logic                 if_valid,
  output logic [31:0]          mem_rdata,
  output logic                 mem_valid,
  output logic                 stall_pipe,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I} state_t;

  state_t        state_q, state_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          mem_valid_q, mem_valid_d;
  logic          err_q, err_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          d_done_q, d_done_d;
  logic          i_done_q, i_done_d;
  logic          flush_seen_q, flush_seen_d;
  logic          kill_q, kill_d;

  logic d_pend, i_pend, timeout_hit, fetch_cancel;

  assign d_pend      = (mem_rd | mem_wr) & ~d_done_q;
  assign i_pend      = if_req & ~i_done_q & ~flush_seen_q;
  assign stall_pipe  = i_pend | d_pend;
  assign timeout_hit = (cnt_q == 5'(TIMEOUT - 1));
  // A fetch flushed while in flight still finishes on the RAM but is dropped.
  assign fetch_cancel = kill_q | flush;

  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_valid_d   = 1'b0;
    mem_valid_d  = 1'b0;
    err_d        = err_q;
    cnt_d        = cnt_q;
    d_done_d     = d_done_q;
    i_done_d     = i_done_q;
    flush_seen_d = flush_seen_q | flush;
    kill_d       = kill_q;

    case (state_q)
      IDLE: begin
        if (d_pend) begin
          state_d = SERVE_D;
          en_d    = 1'b1;
          we_d    = mem_wr;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          cnt_d   = 5'd0;
        end else if (i_pend && !flush) begin
          state_d = SERVE_I;
          en_d    = 1'b1;
          we_d    = 1'b0;
          addr_d  = if_addr;
          cnt_d   = 5'd0;
          kill_d  = 1'b0;
        end
      end

      SERVE_D: begin
        cnt_d = cnt_q + 5'd1;
        if (ram.ram_ready || timeout_hit) begin
          state_d     = IDLE;
          en_d        = 1'b0;
          we_d        = 1'b0;
          mem_valid_d = 1'b1;
          d_done_d    = 1'b1;
          if (!ram.ram_ready) begin
            mem_rdata_d = 32'd0;
            err_d       = 1'b1;
          end else if (!we_q) begin
            mem_rdata_d = ram.ram_rdata;
          end
        end
      end

      SERVE_I: begin
        cnt_d  = cnt_q + 5'd1;
        kill_d = fetch_cancel;
        if (ram.ram_ready || timeout_hit) begin
          state_d = IDLE;
          en_d    = 1'b0;
          we_d    = 1'b0;
          if (!ram.ram_ready) err_d = 1'b1;
          // A cancelled fetch leaves i_done alone so it cannot leak into a later window.
          if (!fetch_cancel) begin
            if_valid_d = 1'b1;
            i_done_d   = 1'b1;
            if_rdata_d = ram.ram_ready ? ram.ram_rdata : 32'd0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (!stall_pipe) begin
      d_done_d     = 1'b0;
      i_done_d     = 1'b0;
      flush_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      en_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      if_rdata_q   <= 32'd0;
      mem_rdata_q  <= 32'd0;
      if_valid_q   <= 1'b0;
      mem_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= 5'd0;
      d_done_q     <= 1'b0;
      i_done_q     <= 1'b0;
      flush_seen_q <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_valid_q   <= if_valid_d;
      mem_valid_q  <= mem_valid_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      d_done_q     <= d_done_d;
      i_done_q     <= i_done_d;
      flush_seen_q <= flush_seen_d;
      kill_q       <= kill_d;
    end
  end

  assign ram.ram_en    = en_q;
  assign ram.ram_we    = we_q;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;
  assign if_rdata      = if_rdata_q;
  assign if_valid      = if_valid_q;
  assign mem_rdata     = mem_rdata_q;
  assign mem_valid     = mem_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions against a
// latency-programmable RAM model, plus hand-written multi-cycle corner sequences.
module tb_mem_port_arbiter;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, if_req, flush, mem_rd, mem_wr;
  logic [AW-1:0] if_addr, mem_addr;
  logic [31:0]   mem_wdata, if_rdata, mem_rdata;
  logic          if_valid, mem_valid, stall_pipe, err;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(.AW(AW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ram(bus), .if_rdata(if_rdata), .if_valid(if_valid), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .stall_pipe(stall_pipe), .err(err)
  );

  // RAM model: answers in the ready_dly-th cycle (0-based) of an ram_en burst.
  int          ready_dly = 0;
  int          en_idx = 0;
  logic        force_rdy = 1'b0;
  logic [31:0] rdv = 32'd0;
  always @(posedge clk) en_idx <= bus.ram_en ? en_idx + 1 : 0;
  assign bus.ram_ready = force_rdy | (bus.ram_en && (en_idx == ready_dly));
  assign bus.ram_rdata = rdv;

  int errors = 0;
  int checks = 0;

  // Per-sequence observation record.
  int            cyc, n_iv, n_mv, iv_cyc, mv_cyc, n_en, n_rise;
  logic [31:0]   iv_data, mv_data, wd_first;
  logic [AW-1:0] rise_addr [4];
  int            rise_cyc [4];
  logic          we_all, we_any, wd_bad, prev_en;

  typedef struct {
    logic        rd, wr, ireq;
    logic [31:0] maddr, iaddr, wd;
    int          dly;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic        e_we;
    int          e_niv, e_nmv, e_vcyc;
    logic [31:0] e_ifr, e_memr;
    logic        e_err;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_rec();
    cyc = 0; n_iv = 0; n_mv = 0; iv_cyc = -1; mv_cyc = -1; n_en = 0; n_rise = 0;
    iv_data = 32'd0; mv_data = 32'd0; wd_first = 32'd0;
    we_all = 1'b1; we_any = 1'b0; wd_bad = 1'b0; prev_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rise_addr[i] = '0;
      rise_cyc[i]  = -1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (if_valid)  begin n_iv++; iv_cyc = cyc; iv_data = if_rdata;  end
    if (mem_valid) begin n_mv++; mv_cyc = cyc; mv_data = mem_rdata; end
    if (bus.ram_en) begin
      n_en++;
      if (!prev_en) begin
        if (n_rise < 4) begin
          rise_addr[n_rise] = bus.ram_addr;
          rise_cyc[n_rise]  = cyc;
        end
        n_rise++;
        wd_first = bus.ram_wdata;
      end else if (bus.ram_wdata !== wd_first) begin
        wd_bad = 1'b1;
      end
      we_all = we_all & bus.ram_we;
      we_any = we_any | bus.ram_we;
    end
    prev_en = bus.ram_en;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; flush = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = 32'd0;
  endtask

  task automatic apply(input logic rd, input logic wr, input logic ireq,
                       input logic [31:0] maddr, input logic [31:0] iaddr, input logic [31:0] wd);
    @(posedge clk); #1;
    mem_rd = rd; mem_wr = wr; if_req = ireq;
    mem_addr = maddr; if_addr = iaddr; mem_wdata = wd;
  endtask

  // Step until stall_pipe drops, then let the pipeline advance and watch a few idle cycles.
  task automatic run_until_release(input string name, output int fall);
    fall = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!stall_pipe) begin
        fall = cyc;
        break;
      end
    end
    if (fall < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_release: stall_pipe still 1 after 60 cycles, required 0", name);
    end
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic run_vec(input int k);
    int fall;
    string n;
    n = $sformatf("v%0d", k);
    clear_rec();
    ready_dly = vt[k].dly;
    rdv = vt[k].rdata;
    apply(vt[k].rd, vt[k].wr, vt[k].ireq, vt[k].maddr, vt[k].iaddr, vt[k].wd);
    run_until_release(n, fall);
    check({n, "_en_cycle"}, rise_cyc[0], 2);
    check({n, "_bursts"}, n_rise, 1);
    check({n, "_ram_addr"}, rise_addr[0], vt[k].e_addr);
    check({n, "_we_any"}, we_any, vt[k].e_we);
    check({n, "_we_all"}, we_all, vt[k].e_we);
    if (vt[k].e_we) begin
      check({n, "_wdata"}, wd_first, vt[k].wd);
      check({n, "_wdata_stable"}, wd_bad, 0);
    end
    check({n, "_n_if_valid"}, n_iv, vt[k].e_niv);
    check({n, "_n_mem_valid"}, n_mv, vt[k].e_nmv);
    check({n, "_valid_cycle"}, (vt[k].e_niv != 0) ? iv_cyc : mv_cyc, vt[k].e_vcyc);
    check({n, "_stall_fall"}, fall, vt[k].e_vcyc);
    check({n, "_if_rdata"}, if_rdata, vt[k].e_ifr);
    check({n, "_mem_rdata"}, mem_rdata, vt[k].e_memr);
    check({n, "_err"}, err, vt[k].e_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall;
    //        rd    wr    ireq  maddr      iaddr   wd            dly rdata         e_addr     we    iv mv vc  e_ifr         e_memr        e_err
    vt[0] = '{1'b0, 1'b0, 1'b1, 32'h0,     32'h40, 32'h0,        2,  32'h11112222, 32'h40,    1'b0, 1, 0, 5,  32'h11112222, 32'h00000000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 32'h100,   32'h0,  32'h0,        0,  32'hCAFEF00D, 32'h100,   1'b0, 0, 1, 3,  32'h11112222, 32'hCAFEF00D, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 32'h200,   32'h0,  32'hDEADBEEF, 3,  32'h55555555, 32'h200,   1'b1, 0, 1, 6,  32'h11112222, 32'hCAFEF00D, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 32'h300,   32'h0,  32'h0BADC0DE, 1,  32'h66666666, 32'h300,   1'b1, 0, 1, 4,  32'h11112222, 32'hCAFEF00D, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 32'h0,     32'h44, 32'h0,        5,  32'h89ABCDEF, 32'h44,    1'b0, 1, 0, 8,  32'h89ABCDEF, 32'hCAFEF00D, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 32'h104,   32'h0,  32'h0,        14, 32'h76543210, 32'h104,   1'b0, 0, 1, 17, 32'h89ABCDEF, 32'h76543210, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 32'h108,   32'h0,  32'h0,        15, 32'h0F0F0F0F, 32'h108,   1'b0, 0, 1, 18, 32'h89ABCDEF, 32'h0F0F0F0F, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b1, 32'h0,     32'h4C, 32'h0,        0,  32'h24682468, 32'h4C,    1'b0, 1, 0, 3,  32'h24682468, 32'h13572468, 1'b0};
    vt[8] = '{1'b0, 1'b0, 1'b1, 32'h0,     32'h50, 32'h0,        1,  32'h31415926, 32'h50,    1'b0, 1, 0, 4,  32'h31415926, 32'h00000000, 1'b1};

    // Reset state
    rst = 1'b1;
    idle_inputs();
    clear_rec();
    repeat (2) @(posedge clk);
    step();
    check("rst_ram_en", bus.ram_en, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_wdata", bus.ram_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_valids", {if_valid, mem_valid}, 0);
    check("rst_err", err, 0);
    check("rst_stall", stall_pipe, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 7; k++) run_vec(k);

    // Fetch and load together: data first, then fetch, stall held across both.
    clear_rec();
    ready_dly = 1;
    rdv = 32'h13572468;
    apply(1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 32'h0);
    run_until_release("both", fall);
    check("both_bursts", n_rise, 2);
    check("both_d_en_cycle", rise_cyc[0], 2);
    check("both_d_addr", rise_addr[0], 32'h100);
    check("both_mem_valid_cycle", mv_cyc, 4);
    check("both_i_en_cycle", rise_cyc[1], 5);
    check("both_i_addr", rise_addr[1], 32'h80);
    check("both_if_valid_cycle", iv_cyc, 7);
    check("both_stall_fall", fall, 7);
    check("both_counts", {n_iv[7:0], n_mv[7:0]}, 16'h0101);
    check("both_rdatas", {if_rdata, mem_rdata}, 64'h13572468_13572468);

    // Flush while the fetch is in flight: RAM finishes, no if_valid.
    clear_rec();
    ready_dly = 3;
    rdv = 32'hAAAA5555;
    apply(1'b0, 1'b0, 1'b1, 32'h0, 32'h48, 32'h0);
    step();
    step();
    @(posedge clk); #1;
    flush = 1'b1;
    step();
    @(posedge clk); #1;
    flush = 1'b0;
    if_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("fl_serve_bursts", n_rise, 1);
    check("fl_serve_en_cycles", n_en, 4);
    check("fl_serve_no_if_valid", n_iv, 0);
    check("fl_serve_if_rdata", if_rdata, 32'h13572468);
    check("fl_serve_stall", stall_pipe, 0);
    check("fl_serve_err", err, 0);
    run_vec(7);

    // Flush in IDLE: the fetch is never launched.
    clear_rec();
    apply(1'b0, 1'b0, 1'b1, 32'h0, 32'h60, 32'h0);
    flush = 1'b1;
    step();
    check("fl_idle_stall_c1", stall_pipe, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    step();
    check("fl_idle_stall_c2", stall_pipe, 0);
    @(posedge clk); #1;
    if_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("fl_idle_no_burst", n_rise, 0);
    check("fl_idle_no_if_valid", n_iv, 0);

    // RAM never answers: abort after 16 SERVE cycles.
    clear_rec();
    ready_dly = 99;
    rdv = 32'h77777777;
    apply(1'b1, 1'b0, 1'b0, 32'h1F0, 32'h0, 32'h0);
    run_until_release("tmo", fall);
    check("tmo_en_cycles", n_en, 16);
    check("tmo_en_cycle", rise_cyc[0], 2);
    check("tmo_mem_valid_cycle", mv_cyc, 18);
    check("tmo_n_mem_valid", n_mv, 1);
    check("tmo_valid_data", mv_data, 0);
    check("tmo_stall_fall", fall, 18);
    check("tmo_err", err, 1);

    // ram_ready with no transaction is ignored.
    clear_rec();
    force_rdy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    force_rdy = 1'b0;
    check("idle_ready_valids", n_iv + n_mv, 0);
    check("idle_ready_bursts", n_rise, 0);

    run_vec(8);

    // Reset in the middle of a load.
    clear_rec();
    ready_dly = 10;
    rdv = 32'h12121212;
    apply(1'b1, 1'b0, 1'b0, 32'h2A0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    check("mrst_busy_en", bus.ram_en, 1);
    check("mrst_busy_addr", bus.ram_addr, 32'h2A0);
    rst = 1'b1;
    idle_inputs();
    step();
    check("mrst_ram_en", bus.ram_en, 0);
    check("mrst_ram_we", bus.ram_we, 0);
    check("mrst_ram_addr", bus.ram_addr, 0);
    check("mrst_ram_wdata", bus.ram_wdata, 0);
    check("mrst_if_rdata", if_rdata, 0);
    check("mrst_mem_rdata", mem_rdata, 0);
    check("mrst_valids", {if_valid, mem_valid}, 0);
    check("mrst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("mrst_no_valid", n_mv + n_iv, 0);
    check("mrst_bursts", n_rise, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: AW, default 32, address width in bits.
REQ-002 Parameter: TIMEOUT, default 16, maximum number of SERVE cycles per RAM transaction before it is aborted.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 if_req  in  1  fetch stage requests an instruction word.
REQ-006 if_addr  in  AW  fetch address.
REQ-007 flush  in  1  branch/jump taken; cancels the fetch for the current stall window.
REQ-008 mem_rd / mem_wr  in  1 each  data read / data write request from the MEM stage.
REQ-009 mem_addr  in  AW; mem_wdata  in  32  data address and store data.
REQ-010 ram_en  out  1; ram_we  out  1; ram_addr  out  AW; ram_wdata  out  32  single-port RAM command.
REQ-011 ram_ready  in  1; ram_rdata  in  32  RAM completion strobe and read data.
REQ-012 if_rdata  out  32; if_valid  out  1  fetched word and its one-cycle valid pulse.
REQ-013 mem_rdata  out  32; mem_valid  out  1  load data and its one-cycle valid pulse.
REQ-014 stall_pipe  out  1  freezes all pipeline registers.
REQ-015 err  out  1  sticky timeout flag.

Function
REQ-016 The block SHALL implement the states IDLE, SERVE_D and SERVE_I, with all outputs registered except stall_pipe.
REQ-017 The block SHALL keep two window flags, d_done and i_done, and SHALL drive stall_pipe = (if_req & ~i_done & ~flush_seen) | ((mem_rd|mem_wr) & ~d_done).
REQ-018 The pipeline holds all request inputs stable while stall_pipe=1; the flags SHALL clear on the first clock edge at which stall_pipe=0.
REQ-019 From IDLE, a pending data request SHALL go to SERVE_D with priority over fetch; otherwise a pending, unflushed fetch SHALL go to SERVE_I.
REQ-020 On entry to a SERVE state the block SHALL latch the address and write data, assert ram_en=1, and set ram_we=1 only for a data write.
REQ-021 ram_en SHALL stay at 1 for the whole SERVE state.
REQ-022 If mem_rd and mem_wr are both 1, the access SHALL be treated as a write.
REQ-023 Latency: a request seen in IDLE at cycle t SHALL produce ram_en=1 at t+1.
REQ-024 When ram_ready=1 is sampled at cycle t+k, the block SHALL, at t+k+1, capture ram_rdata into the matching rdata register, pulse the matching valid for one cycle, set the matching done flag, drop ram_en and return to IDLE.
REQ-025 A data write SHALL pulse mem_valid and leave mem_rdata unchanged.
REQ-026 A 5-bit cycle counter SHALL clear on SERVE entry and increment each SERVE cycle.
REQ-027 If the counter reaches TIMEOUT-1 with ram_ready=0, the block SHALL abort the transaction: return to IDLE, set rdata to 0, pulse valid, set the done flag and set err=1.
REQ-028 err SHALL clear only on rst.
REQ-029 flush=1 in any cycle SHALL set flush_seen, which clears together with the done flags.
REQ-030 A flush during SERVE_I SHALL let the RAM transaction complete while suppressing if_valid, leaving if_rdata unchanged.
REQ-031 A flush in IDLE SHALL prevent entry to SERVE_I for the current window.
REQ-032 ram_ready sampled while in IDLE SHALL be ignored.
REQ-033 Back-to-back: IDLE SHALL be able to launch the next transaction in the cycle right after a completion.

Reset
REQ-034 While rst=1 at a clock edge, the block SHALL force state=IDLE, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, mem_rdata=0, if_valid=0, mem_valid=0, err=0, the counter to 0, and d_done=i_done=flush_seen=0.
REQ-035 Reset SHALL take priority over every other input.
REQ-036 A reset asserted mid-SERVE SHALL abandon the transaction with no valid pulse.

Verification
REQ-037 Fetch only: if_req=1, if_addr=0x40, ram_ready returned 2 cycles after ram_en -> if_valid pulses once with if_rdata=ram_rdata, then stall_pipe=0.
REQ-038 Both requests: if_req=1 and mem_rd=1 at mem_addr=0x100 -> data serviced first (ram_addr=0x100), then fetch; stall_pipe=1 until both valid pulses have occurred.
REQ-039 Store: mem_wr=1, mem_wdata=0xDEADBEEF -> ram_we=1 and ram_wdata=0xDEADBEEF for the whole SERVE_D; mem_valid pulses; mem_rdata unchanged.
REQ-040 Flush during SERVE_I -> ram transaction completes, no if_valid pulse, stall_pipe falls after completion.
REQ-041 ram_ready held at 0 with TIMEOUT=16 -> abort after 16 SERVE cycles, valid pulses with rdata=0, err=1 until rst.
REQ-042 rst=1 mid-SERVE_D -> next cycle: all outputs at reset values, no valid pulse.
